// File: rtl/boot_loader_ctrl.sv
// Byte-stream bootloader: takes a length-prefixed little-endian image over valid/ready,
// writes it word by word into instruction memory, then releases the core from reset.
module boot_loader_ctrl #(
   parameter int unsigned ADDR_BITS      = 10,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           rx_data,
   input  logic                 rx_valid,
   output logic                 rx_ready,
   input  logic                 boot_start,
   output logic                 core_rst,
   output logic [3:0]           mem_w_enb,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [31:0]          mem_w_data,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_BITS-2:0] words_loaded
);

   localparam int unsigned MAX_WORDS = 2 ** (ADDR_BITS - 2);
   localparam int unsigned WB        = ADDR_BITS - 1;

   typedef enum logic [2:0] {S_HDR, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

   state_t        state;
   logic [1:0]    byte_idx;
   logic [23:0]   byte_buf;
   logic [WB-1:0] n_words;
   logic [31:0]   idle_cnt;
   logic          accept;
   logic [31:0]   full_word;
   logic [WB-1:0] next_k;
   logic          idle_run;
   logic          timeout_hit;

   assign rx_ready  = (state == S_HDR) || (state == S_LOAD);
   assign busy      = rx_ready || (state == S_WRITE);
   assign accept    = rx_valid && rx_ready;
   assign full_word = {rx_data, byte_buf};
   assign next_k    = words_loaded + WB'(1);

   // Idle time only counts once a transfer is actually under way.
   assign idle_run    = (TIMEOUT_CYCLES != 0) &&
                        ((state == S_LOAD) || ((state == S_HDR) && (byte_idx != 2'd0)));
   assign timeout_hit = idle_run && !accept && (idle_cnt == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_HDR;
         byte_idx     <= '0;
         byte_buf     <= '0;
         n_words      <= '0;
         idle_cnt     <= '0;
         core_rst     <= 1'b1;
         mem_w_enb    <= '0;
         mem_addr     <= '0;
         mem_w_data   <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= '0;
      end else begin
         mem_w_enb <= '0;

         if (accept)
            idle_cnt <= '0;
         else if (idle_run)
            idle_cnt <= idle_cnt + 32'd1;

         if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0:    byte_buf[7:0]   <= rx_data;
               2'd1:    byte_buf[15:8]  <= rx_data;
               2'd2:    byte_buf[23:16] <= rx_data;
               default: ;
            endcase
         end

         case (state)
            S_HDR: begin
               if (timeout_hit) begin
                  state <= S_ERR;
                  error <= 1'b1;
               end else if (accept && (byte_idx == 2'd3)) begin
                  if (full_word == 32'd0) begin
                     state    <= S_DONE;
                     core_rst <= 1'b0;
                     done     <= 1'b1;
                  end else if (full_word > MAX_WORDS) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else begin
                     n_words <= full_word[WB-1:0];
                     state   <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (timeout_hit) begin
                  state <= S_ERR;
                  error <= 1'b1;
               end else if (accept && (byte_idx == 2'd3)) begin
                  mem_w_enb  <= 4'hF;
                  mem_addr   <= {words_loaded[WB-2:0], 2'b00};
                  mem_w_data <= full_word;
                  state      <= S_WRITE;
               end
            end
            S_WRITE: begin
               words_loaded <= next_k;
               if (next_k == n_words) begin
                  state    <= S_DONE;
                  core_rst <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  state <= S_LOAD;
               end
            end
            S_DONE, S_ERR: begin
               if (boot_start) begin
                  state        <= S_HDR;
                  core_rst     <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= '0;
                  byte_idx     <= '0;
                  idle_cnt     <= '0;
               end
            end
            default: state <= S_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: expected memory writes are queued as bytes are
// driven and popped by a write monitor; status outputs are checked at fixed points.
module tb_boot_loader_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        boot_start = 1'b0;
   logic        core_rst;
   logic [3:0]  mem_w_enb;
   logic [9:0]  mem_addr;
   logic [31:0] mem_w_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [8:0]  words_loaded;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   boot_loader_ctrl #(.ADDR_BITS(10), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .boot_start(boot_start), .core_rst(core_rst), .mem_w_enb(mem_w_enb),
      .mem_addr(mem_addr), .mem_w_data(mem_w_data), .busy(busy), .done(done),
      .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write monitor: every mem_w_enb pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mem_w_enb !== 4'h0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_enb", 32'(mem_w_enb), 32'hF);
            check("wr_addr", 32'(mem_addr), 32'(e.addr));
            check("wr_data", mem_w_data, e.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int stalls);
      stalls = 0;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && stalls < 100) begin
         @(negedge clk);
         stalls++;
      end
      if (stalls >= 100) check("rx_ready_wait", 32'(stalls), 32'd0);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] n);
      int s;
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], s);
   endtask

   task automatic send_word(input logic [9:0] addr, input logic [31:0] data, output int first_stall);
      int s;
      wr_t e;
      e.addr = addr;
      e.data = data;
      exp_q.push_back(e);
      for (int i = 0; i < 4; i++) begin
         send_byte(data[8*i +: 8], s);
         if (i == 0) first_stall = s;
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      boot_start = 1'b1;
      @(posedge clk);
      #1 boot_start = 1'b0;
      check("rearm_busy", 32'(busy), 32'd1);
      check("rearm_error", 32'(error), 32'd0);
      check("rearm_done", 32'(done), 32'd0);
      check("rearm_core_rst", 32'(core_rst), 32'd1);
      check("rearm_words", 32'(words_loaded), 32'd0);
   endtask

   initial begin
      int st;
      logic [31:0] d;

      // Reset state
      #12;
      check("rst_core_rst", 32'(core_rst), 32'd1);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wenb", 32'(mem_w_enb), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_rx_ready", 32'(rx_ready), 32'd1);

      // Two-word image with backpressure on the byte following each WRITE
      send_hdr(32'd2);
      send_word(10'h000, 32'h0010_0013, st);
      check("first_word_stall", 32'(st), 32'd0);
      send_word(10'h004, 32'h0020_0093, st);
      check("bp_stall", 32'(st), 32'd1);
      check("t1_pre_core_rst", 32'(core_rst), 32'd1);
      check("t1_in_write_ready", 32'(rx_ready), 32'd0);
      @(posedge clk);
      #1;
      check("t1_core_rst", 32'(core_rst), 32'd0);
      check("t1_done", 32'(done), 32'd1);
      check("t1_words", 32'(words_loaded), 32'd2);
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_pending", 32'(exp_q.size()), 32'd0);

      // Boot_start is honoured in DONE; empty image goes straight to DONE
      pulse_start();
      send_hdr(32'd0);
      check("t2_done", 32'(done), 32'd1);
      check("t2_core_rst", 32'(core_rst), 32'd0);
      check("t2_words", 32'(words_loaded), 32'd0);
      repeat (3) @(posedge clk);

      // Oversize image is rejected
      pulse_start();
      send_hdr(32'd257);
      check("t3_error", 32'(error), 32'd1);
      check("t3_core_rst", 32'(core_rst), 32'd1);
      check("t3_ready", 32'(rx_ready), 32'd0);
      check("t3_busy", 32'(busy), 32'd0);

      // Maximum image fills the whole memory
      pulse_start();
      send_hdr(32'd256);
      for (int k = 0; k < 256; k++) begin
         d = $urandom;
         send_word(10'(k * 4), d, st);
      end
      @(posedge clk);
      #1;
      check("t3_max_done", 32'(done), 32'd1);
      check("t3_max_words", 32'(words_loaded), 32'd256);
      check("t3_max_pending", 32'(exp_q.size()), 32'd0);

      // Header idle before the first byte never times out; mid-transfer idle does
      pulse_start();
      repeat (40) @(posedge clk);
      #1 check("t5_hdr_idle_error", 32'(error), 32'd0);
      send_hdr(32'd1);
      send_byte(8'hAA, st);
      send_byte(8'h55, st);
      repeat (15) @(posedge clk);
      #1 check("t5_pre_timeout", 32'(error), 32'd0);
      @(posedge clk);
      #1;
      check("t5_timeout_error", 32'(error), 32'd1);
      check("t5_core_rst", 32'(core_rst), 32'd1);
      pulse_start();

      // Async reset between bytes of word 3, then a full reload
      send_hdr(32'd4);
      send_word(10'h000, 32'h1111_2222, st);
      send_word(10'h004, 32'h3333_4444, st);
      send_word(10'h008, 32'h5555_6666, st);
      send_byte(8'h77, st);
      send_byte(8'h88, st);
      #2 rst = 1'b1;
      #1;
      check("t6_core_rst", 32'(core_rst), 32'd1);
      check("t6_wenb", 32'(mem_w_enb), 32'd0);
      check("t6_addr", 32'(mem_addr), 32'd0);
      check("t6_wdata", mem_w_data, 32'd0);
      check("t6_busy", 32'(busy), 32'd1);
      check("t6_done", 32'(done), 32'd0);
      check("t6_error", 32'(error), 32'd0);
      check("t6_words", 32'(words_loaded), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 check("t6_rx_ready", 32'(rx_ready), 32'd1);
      send_hdr(32'd2);
      send_word(10'h000, 32'hDEAD_BEEF, st);
      send_word(10'h004, 32'h0BAD_F00D, st);
      @(posedge clk);
      #1;
      check("t6_reload_done", 32'(done), 32'd1);
      check("t6_reload_words", 32'(words_loaded), 32'd2);
      repeat (3) @(posedge clk);
      check("final_pending", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
